// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 parity_en;
    logic                 parity_odd;

    modport master (
        output tx_data,
        output tx_valid,
        output parity_en,
        output parity_odd,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  parity_en,
        input  parity_odd,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits.
// Bit boundaries are the rising edges of baud_clk seen in the clk domain.
module uart_tx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      baud_clk,
    uart_tx_if.slave  bus,
    output logic      serial_out,
    output logic      tx_busy,
    output logic      tx_done
);
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_baud_q;
    logic                 w_tick;
    logic                 r_ready;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     w_bit_cnt_nxt;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nxt;
    logic                 r_par_en;
    logic                 w_par_en_nxt;
    logic                 r_par_bit;
    logic                 w_par_bit_nxt;
    logic                 w_serial_nxt;
    logic                 w_done_nxt;
    logic                 w_accept;

    assign w_tick       = baud_clk & ~r_baud_q;
    assign w_accept     = bus.tx_valid & r_ready;
    assign bus.tx_ready = r_ready;

    // Baud edge detector history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_q <= 1'b0;
        end else begin
            r_baud_q <= baud_clk;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            serial_out <= 1'b1;
            r_ready    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            serial_out <= w_serial_nxt;
            r_ready    <= (w_state_nxt == S_IDLE);
            tx_busy    <= (w_state_nxt != S_IDLE);
            tx_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output decode; everything but the accept waits for a tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_serial_nxt   = serial_out;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_serial_nxt = 1'b1;
                if (w_accept) begin
                    w_shift_nxt    = bus.tx_data;
                    w_par_en_nxt   = bus.parity_en;
                    w_par_bit_nxt  = (^bus.tx_data) ^ bus.parity_odd;
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_SYNC;
                end
            end
            S_SYNC: begin
                // Wait for a tick so the start bit spans a whole bit period.
                if (w_tick) begin
                    w_serial_nxt = 1'b0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_serial_nxt  = r_shift[0];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt < LAST_BIT) begin
                        w_shift_nxt   = r_shift >> 1;
                        w_serial_nxt  = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end else if (r_par_en) begin
                        w_serial_nxt = r_par_bit;
                        w_state_nxt  = S_PARITY;
                    end else begin
                        w_serial_nxt   = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_serial_nxt   = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_serial_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end
endmodule
